// File: rtl/motor_pkg.sv
// motor_pkg: shared state encoding, H-bridge codes and default parameters for the motor ramp controller.
//   Exports ch_state_t (IDLE/RUN/DRAIN/DEAD), bridge_t with FWD/REV/COAST/BRAKE,
//   DEF_* default parameter values and dir_code() mapping a direction bit to a bridge code.
package motor_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DEAD} ch_state_t;

    // {in_a, in_b}
    typedef logic [1:0] bridge_t;
    localparam bridge_t FWD   = 2'b10;
    localparam bridge_t REV   = 2'b01;
    localparam bridge_t COAST = 2'b00;
    localparam bridge_t BRAKE = 2'b11;

    localparam int DEF_N_CH         = 2;
    localparam int DEF_DUTY_W       = 10;
    localparam int DEF_PERIOD       = 4000;
    localparam int DEF_STEP         = 16;
    localparam int DEF_DEAD_PERIODS = 4;

    function automatic bridge_t dir_code(input logic dir);
        return dir ? FWD : REV;
    endfunction

endpackage

// File: rtl/motor_ramp_channel.sv
// motor_ramp_channel: one motor channel -- duty ramping, reversal drain/dead-time, PWM and H-bridge drive.
//   clk, reset   : clock, asynchronous active-high reset
//   tick, count  : shared period strobe and period counter from the top level
//   estop        : level-sensitive emergency stop (brake, duty 0)
//   enable, tgt_dir, tgt_duty : run request, direction and target duty, sampled on tick
//   pwm, in_a, in_b, busy, cur_duty : registered PWM, bridge inputs, non-IDLE flag, applied duty
module motor_ramp_channel
    import motor_pkg::*;
#(
    parameter int DUTY_W       = DEF_DUTY_W,
    parameter int PERIOD       = DEF_PERIOD,
    parameter int STEP         = DEF_STEP,
    parameter int DEAD_PERIODS = DEF_DEAD_PERIODS,
    parameter int CW           = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tick,
    input  logic [CW-1:0]     count,
    input  logic              estop,
    input  logic              enable,
    input  logic              tgt_dir,
    input  logic [DUTY_W-1:0] tgt_duty,
    output logic              pwm,
    output logic              in_a,
    output logic              in_b,
    output logic              busy,
    output logic [DUTY_W-1:0] cur_duty
);

    localparam int DW = DEAD_PERIODS > 0 ? $clog2(DEAD_PERIODS + 1) : 1;
    localparam int PW = DUTY_W + 32;
    localparam logic [DUTY_W-1:0] STEP_D = DUTY_W'(STEP);

    ch_state_t         state;
    logic              dir;
    logic [DW-1:0]     dead_cnt;
    bridge_t           bridge;
    logic [DUTY_W-1:0] eff, diff, stp, toward, dstp, drained;
    logic [PW-1:0]     thr;
    logic              duty_on;

    assign {in_a, in_b} = bridge;
    assign busy         = state != IDLE;

    // Step sizes are clamped to the remaining distance, so the ramp never overshoots or wraps.
    always_comb begin
        eff     = enable ? tgt_duty : '0;
        diff    = eff > cur_duty ? eff - cur_duty : cur_duty - eff;
        stp     = int'(diff) > STEP ? STEP_D : diff;
        toward  = eff > cur_duty ? cur_duty + stp : cur_duty - stp;
        dstp    = int'(cur_duty) > STEP ? STEP_D : cur_duty;
        drained = cur_duty - dstp;
        thr     = (PW'(cur_duty) * PW'(PERIOD)) >> DUTY_W;
        duty_on = PW'(count) < thr;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            dir      <= 1'b0;
            cur_duty <= '0;
            dead_cnt <= '0;
            bridge   <= COAST;
            pwm      <= 1'b0;
        end else if (estop) begin
            state    <= IDLE;
            cur_duty <= '0;
            dead_cnt <= '0;
            bridge   <= BRAKE;
            pwm      <= 1'b0;
        end else begin
            pwm <= (state == RUN || state == DRAIN) && duty_on;
            // Brake is only ever left over from an estop; release to coast at once.
            if (bridge == BRAKE)
                bridge <= COAST;
            if (tick) begin
                case (state)
                    IDLE: if (eff != '0) begin
                        state    <= RUN;
                        dir      <= tgt_dir;
                        cur_duty <= toward;
                        bridge   <= dir_code(tgt_dir);
                    end
                    RUN: if (tgt_dir != dir) begin
                        state    <= DRAIN;
                        cur_duty <= drained;
                    end else if (cur_duty == '0 && eff == '0) begin
                        state  <= IDLE;
                        bridge <= COAST;
                    end else begin
                        cur_duty <= toward;
                    end
                    DRAIN: begin
                        cur_duty <= drained;
                        if (drained == '0) begin
                            state    <= DEAD;
                            dead_cnt <= DW'(DEAD_PERIODS);
                            bridge   <= COAST;
                        end
                    end
                    DEAD: if (dead_cnt <= DW'(1)) begin
                        // Last coast period ends on this tick.
                        dead_cnt <= '0;
                        if (eff != '0) begin
                            state    <= RUN;
                            dir      <= tgt_dir;
                            cur_duty <= toward;
                            bridge   <= dir_code(tgt_dir);
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        dead_cnt <= dead_cnt - DW'(1);
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: rtl/motor_ramp_ctrl.sv
// motor_ramp_ctrl: multi-channel H-bridge motor controller with ramped PWM duty and safe reversal.
//   clk, reset : clock, asynchronous active-high reset
//   enable, tgt_dir, tgt_duty : per-channel run request, direction, packed target duty
//   estop      : emergency stop for all channels
//   pwm, in_a, in_b, busy, cur_duty : per-channel PWM, bridge inputs, activity, packed applied duty
module motor_ramp_ctrl
    import motor_pkg::*;
#(
    parameter int N_CH         = DEF_N_CH,
    parameter int DUTY_W       = DEF_DUTY_W,
    parameter int PERIOD       = DEF_PERIOD,
    parameter int STEP         = DEF_STEP,
    parameter int DEAD_PERIODS = DEF_DEAD_PERIODS
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_CH-1:0]        enable,
    input  logic [N_CH-1:0]        tgt_dir,
    input  logic [N_CH*DUTY_W-1:0] tgt_duty,
    input  logic                   estop,
    output logic [N_CH-1:0]        pwm,
    output logic [N_CH-1:0]        in_a,
    output logic [N_CH-1:0]        in_b,
    output logic [N_CH-1:0]        busy,
    output logic [N_CH*DUTY_W-1:0] cur_duty
);

    localparam int CW = PERIOD > 1 ? $clog2(PERIOD) : 1;

    logic [CW-1:0] count;
    logic          tick;

    assign tick = count == CW'(PERIOD - 1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            count <= '0;
        else
            count <= tick ? '0 : count + CW'(1);
    end

    genvar k;
    generate
        for (k = 0; k < N_CH; k++) begin : g_ch
            motor_ramp_channel #(
                .DUTY_W      (DUTY_W),
                .PERIOD      (PERIOD),
                .STEP        (STEP),
                .DEAD_PERIODS(DEAD_PERIODS),
                .CW          (CW)
            ) u_ch (
                .clk     (clk),
                .reset   (reset),
                .tick    (tick),
                .count   (count),
                .estop   (estop),
                .enable  (enable[k]),
                .tgt_dir (tgt_dir[k]),
                .tgt_duty(tgt_duty[k*DUTY_W +: DUTY_W]),
                .pwm     (pwm[k]),
                .in_a    (in_a[k]),
                .in_b    (in_b[k]),
                .busy    (busy[k]),
                .cur_duty(cur_duty[k*DUTY_W +: DUTY_W])
            );
        end
    endgenerate

endmodule
